// File: rtl/bid_txn_sequencer.sv
// Bid-auction sequencer: four masters bid for one shared slave path; the winner is
// charged its effective bid, balances refill periodically and starved masters are forced.
module bid_txn_sequencer #(
    parameter int NM            = 4,
    parameter int BID_W         = 4,
    parameter int BAL_W         = 16,
    parameter int INIT_BAL      = 900,
    parameter int MAX_BAL       = 1000,
    parameter int REFILL_AMT    = 50,
    parameter int REFILL_PERIOD = 64,
    parameter int STARVE_LIMIT  = 7,
    parameter int TXN_TIMEOUT   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NM-1:0]       req_valid_i,
    input  logic [NM*BID_W-1:0] bid_i,
    input  logic                txn_done_i,
    output logic [NM-1:0]       grant_o,
    output logic                grant_valid_o,
    output logic [1:0]          grant_id_o,
    output logic                txn_abort_o,
    output logic [NM-1:0]       starve_o,
    output logic [NM*BAL_W-1:0] balance_o
);

    localparam int AGE_W = $clog2(STARVE_LIMIT + 1);
    localparam int TMO_W = $clog2(TXN_TIMEOUT);
    localparam int REF_W = $clog2(REFILL_PERIOD);

    typedef enum logic [1:0] {IDLE = 2'd0, RESOLVE = 2'd1, GRANT = 2'd2, CHARGE = 2'd3} state_t;

    state_t             state_q, state_d;
    logic [NM-1:0]      req_q, req_d;
    logic [BID_W-1:0]   eb_q [NM];
    logic [BID_W-1:0]   eb_d [NM];
    logic [AGE_W-1:0]   age_q [NM];
    logic [AGE_W-1:0]   age_d [NM];
    logic [BAL_W-1:0]   bal_q [NM];
    logic [BAL_W-1:0]   bal_d [NM];
    logic [1:0]         win_q, win_d;
    logic [NM-1:0]      grant_q, grant_d;
    logic               gv_q, gv_d;
    logic [1:0]         gid_q, gid_d;
    logic               abort_q, abort_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [REF_W-1:0]   ref_q, ref_d;
    logic               refill_tick_s;
    logic               charge_s;
    logic [NM-1:0]      starve_s;
    logic [1:0]         winner_s;

    function automatic logic [BID_W-1:0] eff_bid(input logic [BID_W-1:0] b, input logic [BAL_W-1:0] bal);
        logic [BID_W-1:0] r;
        if ({{(BAL_W-BID_W){1'b0}}, b} < bal) r = b;
        else                                   r = bal[BID_W-1:0];
        return r;
    endfunction

    // Arithmetic is one bit wider than the balance so neither borrow nor carry can wrap.
    function automatic logic [BAL_W-1:0] sub_floor(input logic [BAL_W-1:0] bal, input logic [BID_W-1:0] eb);
        logic [BAL_W:0] diff;
        diff = {1'b0, bal} - {{(BAL_W+1-BID_W){1'b0}}, eb};
        return diff[BAL_W] ? {BAL_W{1'b0}} : diff[BAL_W-1:0];
    endfunction

    function automatic logic [BAL_W-1:0] add_ceil(input logic [BAL_W-1:0] bal);
        logic [BAL_W:0] sum;
        sum = {1'b0, bal} + (BAL_W+1)'(REFILL_AMT);
        return (sum > (BAL_W+1)'(MAX_BAL)) ? BAL_W'(MAX_BAL) : sum[BAL_W-1:0];
    endfunction

    // Starve flags and packed balance view from registered state.
    always_comb begin
        for (int i = 0; i < NM; i++) begin
            starve_s[i]                  = (age_q[i] == AGE_W'(STARVE_LIMIT));
            balance_o[i*BAL_W +: BAL_W]  = bal_q[i];
        end
    end

    // Winner selection: lowest-index starved requester, else highest eb, then oldest, then lowest index.
    always_comb begin
        logic             found, take, stv_any;
        logic [1:0]       stv_win, bid_win;
        logic [BID_W-1:0] best_eb;
        logic [AGE_W-1:0] best_age;
        found    = 1'b0;
        take     = 1'b0;
        best_eb  = '0;
        best_age = '0;
        bid_win  = 2'd0;
        stv_win  = 2'd0;
        stv_any  = |(req_q & starve_s);
        for (int i = NM-1; i >= 0; i--) begin
            stv_win = (req_q[i] && starve_s[i]) ? 2'(i) : stv_win;
        end
        for (int i = 0; i < NM; i++) begin
            take     = req_q[i] && (!found || (eb_q[i] > best_eb) ||
                                    ((eb_q[i] == best_eb) && (age_q[i] > best_age)));
            bid_win  = take ? 2'(i) : bid_win;
            best_eb  = take ? eb_q[i] : best_eb;
            best_age = take ? age_q[i] : best_age;
            found    = found | take;
        end
        winner_s = stv_any ? stv_win : bid_win;
    end

    // Auction FSM next-state, grant generation and age bookkeeping.
    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        eb_d     = eb_q;
        age_d    = age_q;
        win_d    = win_q;
        grant_d  = '0;
        gv_d     = 1'b0;
        gid_d    = 2'd0;
        abort_d  = 1'b0;
        tmo_d    = tmo_q;
        charge_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req_valid_i) begin
                    req_d = req_valid_i;
                    for (int i = 0; i < NM; i++) begin
                        eb_d[i] = eff_bid(bid_i[i*BID_W +: BID_W], bal_q[i]);
                    end
                    state_d = RESOLVE;
                end else begin
                    state_d = IDLE;
                end
            end
            RESOLVE: begin
                win_d   = winner_s;
                grant_d = NM'(1) << winner_s;
                gv_d    = 1'b1;
                gid_d   = winner_s;
                tmo_d   = '0;
                state_d = GRANT;
            end
            GRANT: begin
                if (txn_done_i) begin
                    state_d = CHARGE;
                end else if (tmo_q == TMO_W'(TXN_TIMEOUT-1)) begin
                    state_d = CHARGE;
                    abort_d = 1'b1;
                end else begin
                    grant_d = grant_q;
                    gv_d    = gv_q;
                    gid_d   = gid_q;
                    tmo_d   = tmo_q + TMO_W'(1);
                end
            end
            CHARGE: begin
                charge_s = 1'b1;
                for (int i = 0; i < NM; i++) begin
                    if (2'(i) == win_q) begin
                        age_d[i] = '0;
                    end else if (req_q[i] && (age_q[i] != AGE_W'(STARVE_LIMIT))) begin
                        age_d[i] = age_q[i] + AGE_W'(1);
                    end else begin
                        age_d[i] = age_q[i];
                    end
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Balance update: winner charge first, then refill on the same edge if the tick lands there.
    always_comb begin
        logic [BAL_W-1:0] base;
        base          = '0;
        refill_tick_s = (ref_q == REF_W'(REFILL_PERIOD-1));
        ref_d         = refill_tick_s ? '0 : ref_q + REF_W'(1);
        for (int i = 0; i < NM; i++) begin
            base     = (charge_s && (2'(i) == win_q)) ? sub_floor(bal_q[i], eb_q[i]) : bal_q[i];
            bal_d[i] = refill_tick_s ? add_ceil(base) : base;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= '0;
            win_q   <= 2'd0;
            grant_q <= '0;
            gv_q    <= 1'b0;
            gid_q   <= 2'd0;
            abort_q <= 1'b0;
            tmo_q   <= '0;
            ref_q   <= '0;
            for (int i = 0; i < NM; i++) begin
                eb_q[i]  <= '0;
                age_q[i] <= '0;
                bal_q[i] <= BAL_W'(INIT_BAL);
            end
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            win_q   <= win_d;
            grant_q <= grant_d;
            gv_q    <= gv_d;
            gid_q   <= gid_d;
            abort_q <= abort_d;
            tmo_q   <= tmo_d;
            ref_q   <= ref_d;
            for (int i = 0; i < NM; i++) begin
                eb_q[i]  <= eb_d[i];
                age_q[i] <= age_d[i];
                bal_q[i] <= bal_d[i];
            end
        end
    end

    assign grant_o       = grant_q;
    assign grant_valid_o = gv_q;
    assign grant_id_o    = gid_q;
    assign txn_abort_o   = abort_q;
    assign starve_o      = starve_s;

endmodule

// File: tb/tb_bid_txn_sequencer.sv
// Self-checking bench: a reference model of balances/ages/refill predicts winners
// (scoreboard queue) and balances; every comparison goes through check_eq.
module tb_bid_txn_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = 4'd0;
    logic [15:0] bid = 16'd0;
    logic        txn_done = 1'b0;
    logic [3:0]  grant_o;
    logic        grant_valid_o;
    logic [1:0]  grant_id_o;
    logic        txn_abort_o;
    logic [3:0]  starve_o;
    logic [63:0] balance_o;

    bid_txn_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid_i   (req_valid),
        .bid_i         (bid),
        .txn_done_i    (txn_done),
        .grant_o       (grant_o),
        .grant_valid_o (grant_valid_o),
        .grant_id_o    (grant_id_o),
        .txn_abort_o   (txn_abort_o),
        .starve_o      (starve_o),
        .balance_o     (balance_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int bal_m [4];
    int age_m [4];
    int eb_m  [4];
    int ref_cnt;
    bit chg_pend;
    int chg_win;
    int chg_eb;
    logic [3:0] chg_rv;
    int sb_q [$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            bal_m[i] = 900;
            age_m[i] = 0;
        end
        ref_cnt  = 0;
        chg_pend = 1'b0;
    endtask

    // One clock edge; the model applies a pending charge, then any refill tick of that edge.
    task automatic step();
        @(posedge clk);
        if (chg_pend) begin
            bal_m[chg_win] = (bal_m[chg_win] > chg_eb) ? bal_m[chg_win] - chg_eb : 0;
            for (int i = 0; i < 4; i++) begin
                if (i == chg_win)                   age_m[i] = 0;
                else if (chg_rv[i] && age_m[i] < 7) age_m[i] = age_m[i] + 1;
            end
            chg_pend = 1'b0;
        end
        if (ref_cnt == 63) begin
            ref_cnt = 0;
            for (int i = 0; i < 4; i++) bal_m[i] = (bal_m[i] + 50 > 1000) ? 1000 : bal_m[i] + 50;
        end else begin
            ref_cnt++;
        end
        #1;
    endtask

    function automatic int resolve(input logic [3:0] rv);
        int best;
        for (int i = 0; i < 4; i++) if (rv[i] && age_m[i] == 7) return i;
        best = -1;
        for (int i = 0; i < 4; i++)
            if (rv[i] && (best < 0 || eb_m[i] > eb_m[best] ||
                          (eb_m[i] == eb_m[best] && age_m[i] > age_m[best]))) best = i;
        return best;
    endfunction

    task automatic check_state(input string tag);
        logic [3:0] st;
        for (int i = 0; i < 4; i++) begin
            check_eq({tag, "_bal"}, 32'(balance_o[i*16 +: 16]), 32'(bal_m[i]));
            st[i] = (age_m[i] == 7);
        end
        check_eq({tag, "_starve"}, 32'(starve_o), 32'(st));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 4'd0;
        txn_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // done_cyc: GRANT cycle (1..16) in which txn_done is high; 0 = never.
    task automatic auction(input logic [3:0] rv, input logic [15:0] bids, input int done_cyc);
        int win;
        bit ab;
        bit ex;
        for (int i = 0; i < 4; i++)
            eb_m[i] = (int'(bids[i*4 +: 4]) < bal_m[i]) ? int'(bids[i*4 +: 4]) : bal_m[i];
        win = resolve(rv);
        sb_q.push_back(win);
        req_valid = rv;
        bid = bids;
        step();
        req_valid = ~rv;
        bid = 16'($urandom);
        step();
        ab = 1'b0;
        ex = 1'b0;
        for (int g = 1; g <= 16 && !ex; g++) begin
            check_eq("grant_hold", 32'(grant_o), 32'(1) << win);
            check_eq("grant_id", 32'(grant_id_o), 32'(win));
            txn_done = (g == done_cyc);
            ex = (g == done_cyc) || (g == 16);
            ab = (g == 16) && (g != done_cyc);
            step();
        end
        txn_done = 1'b0;
        req_valid = 4'd0;
        check_eq("abort_pulse", 32'(txn_abort_o), 32'(ab));
        check_eq("grant_drop", 32'({grant_valid_o, grant_o}), 32'd0);
        chg_pend = 1'b1;
        chg_win = win;
        chg_eb = eb_m[win];
        chg_rv = rv;
        step();
        check_eq("abort_clr", 32'(txn_abort_o), 32'd0);
        check_state("post");
    endtask

    // Scoreboard: each grant rise pops the predicted winner.
    initial begin
        bit prev;
        int exp;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (grant_valid_o && !prev) begin
                check_eq("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
                if (sb_q.size() > 0) begin
                    exp = sb_q.pop_front();
                    check_eq("sb_grant_id", 32'(grant_id_o), 32'(exp));
                end
            end
            prev = grant_valid_o;
        end
    end

    initial begin
        int cnt;
        int b;
        model_reset();
        do_reset();
        check_eq("rst_grant", 32'({grant_valid_o, grant_id_o, grant_o, txn_abort_o}), 32'd0);
        check_state("rst");

        auction(4'b0101, 16'h0905, 1);
        check_eq("first_bal2", 32'(balance_o[47:32]), 32'd891);

        do_reset();
        auction(4'b1111, 16'h7777, 1);
        auction(4'b1111, 16'h7777, 2);

        do_reset();
        for (int k = 0; k < 7; k++) auction(4'b1001, 16'h100F, 1);
        check_eq("starve3", 32'(starve_o), 32'd8);
        auction(4'b1001, 16'h100F, 1);

        auction(4'b0001, 16'h0004, 0);
        auction(4'b0001, 16'h0004, 16);
        auction(4'b0011, 16'h0035, 3);

        cnt = 0;
        while (bal_m[1] != 3 && cnt < 300) begin
            b = (bal_m[1] >= 18) ? 15 : bal_m[1] - 3;
            auction(4'b0010, 16'((b & 15) << 4), 1);
            cnt++;
        end
        check_eq("bal1_is3", 32'(balance_o[31:16]), 32'd3);
        auction(4'b0110, 16'h0090, 1);
        auction(4'b0110, 16'h0000, 1);

        eb_m[0] = 3;
        sb_q.push_back(0);
        req_valid = 4'b0001;
        bid = 16'h0003;
        step();
        req_valid = 4'd0;
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        check_eq("async_grant", 32'({grant_valid_o, grant_o}), 32'd0);
        model_reset();
        check_state("async_rst");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        repeat (64) step();
        for (int i = 0; i < 4; i++) check_eq("refill1", 32'(balance_o[i*16 +: 16]), 32'd950);
        repeat (64) step();
        for (int i = 0; i < 4; i++) check_eq("refill2", 32'(balance_o[i*16 +: 16]), 32'd1000);
        repeat (64) step();
        check_state("refill3");
        check_eq("refill3_b0", 32'(balance_o[15:0]), 32'd1000);

        auction(4'b1111, 16'h2A6C, 3);
        check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bid_txn_sequencer.md
# bid_txn_sequencer

Registered, multi-cycle bid-auction sequencer that shares one slave-side transaction path between four bidding masters. It runs one auction per transaction: latch bids, pick a winner, hold grant until the slave completes or times out, then charge the winner's balance. Balances refill periodically, and per-master age counters force a win for starved masters. It sits between the master bid interfaces and the slave address decode, replacing purely combinational grant generation with a sequenced, timeout-protected grant.

## Interface
- NM, 4, number of masters (fixed at 4 for this revision)
- BID_W, 4, bid width per master
- BAL_W, 16, balance width per master
- INIT_BAL, 900, balance after reset
- MAX_BAL, 1000, balance saturation ceiling
- REFILL_AMT, 50, amount added to every balance at each refill tick
- REFILL_PERIOD, 64, cycles between refill ticks
- STARVE_LIMIT, 7, lost auctions before a master is force-granted
- TXN_TIMEOUT, 16, maximum cycles in GRANT before abort
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NM  master i is bidding
- bid  in  NM*BID_W  bid of master i at [i*BID_W +: BID_W]
- txn_done  in  1  single-cycle completion pulse from the granted slave
- grant  out  NM  registered one-hot grant
- grant_valid  out  1  OR of grant, registered
- grant_id  out  2  index of granted master, registered
- txn_abort  out  1  one-cycle pulse on transaction timeout
- starve  out  NM  age[i] == STARVE_LIMIT
- balance  out  NM*BAL_W  current balance of master i at [i*BAL_W +: BAL_W]

## Operation
- FSM states: IDLE, RESOLVE, GRANT, CHARGE.
- IDLE: if any req_valid is set, latch req_valid and effective bids, then go to RESOLVE. Otherwise stay.
- Effective bid: eb[i] = min(bid[i], balance[i]). A master with balance 0 stays eligible with eb = 0.
- RESOLVE: choose the winner among latched requesters.
  - If any latched requester has starve set, the lowest-index starved requester wins.
  - Otherwise, highest eb wins.
  - Ties on eb go to the larger age; remaining ties go to the lowest index.
- RESOLVE always exits to GRANT, registering grant, grant_id and grant_valid.
- GRANT: hold the grant. Exit to CHARGE when txn_done = 1, or when the timeout counter reaches TXN_TIMEOUT-1.
  - On timeout without txn_done, pulse txn_abort.
  - If txn_done and timeout coincide, done takes precedence and no abort is raised.
- CHARGE: apply the balance and age updates, then return to IDLE.
  - Winner balance: max(0, bal - eb_latched). The full eb is charged on abort as well.
  - Winner age resets to 0.
  - Each latched losing requester's age increments, saturating at STARVE_LIMIT.
  - Non-requesters keep their age.
- Refill: a free-running counter runs 0..REFILL_PERIOD-1. On wrap, every balance becomes min(MAX_BAL, balance + REFILL_AMT).
- If a refill tick coincides with CHARGE, the winner's balance becomes min(MAX_BAL, max(0, bal - eb) + REFILL_AMT).
- All balance arithmetic is done at BAL_W+1 bits before saturation. No wrap-around is permitted.
- req_valid and bid changes after the IDLE latch are ignored until the next IDLE.

## Timing
- Reset (asynchronous, immediate, including mid-transaction) forces:
  - state to IDLE;
  - grant, grant_valid, grant_id and txn_abort to 0;
  - balance to INIT_BAL, age to 0 and starve to 0;
  - the refill counter and timeout counter to 0.
- Sampling edge T: req_valid is sampled in IDLE. RESOLVE runs at T+1. grant rises at edge T+2.
- grant falls on the edge after the GRANT-state cycle where txn_done is sampled high. That same edge enters CHARGE.
- The balance update is visible after the edge that leaves CHARGE.
- Minimum auction period is 4 cycles (txn_done high in the first GRANT cycle). A back-to-back request is sampled in the IDLE cycle that follows CHARGE.
- Timeout: grant is held for exactly TXN_TIMEOUT cycles. txn_abort is high for the one cycle in which the FSM is in CHARGE.
- grant, grant_valid and grant_id are asserted only in GRANT, and grant is always one-hot or zero.
- starve is combinational from registered age, so it updates one cycle after CHARGE.

## Test plan
- Reset, then req_valid = 4'b0101 with bids 5 and 9 and txn_done one cycle into GRANT.
  - Required: grant = 4'b0100 from T+2 and grant_id = 2.
  - Required: balance[2] = 891, age[0] = 1, grant low at T+4.
- All four masters bid 7 with equal age.
  - Required: master 0 wins.
  - Required: next auction with the same bids (ages 0,1,1,1) goes to master 1.
- Master 3 loses 7 auctions to master 0 (bid 15 versus 1).
  - Required: starve[3] = 1.
  - Required: the next auction is granted to master 3 despite bid 1.
- Hold txn_done low.
  - Required: grant held for 16 cycles, then a single-cycle txn_abort.
  - Required: balance still charged, and the FSM returns to IDLE.
  - Also required: txn_done in the 16th GRANT cycle gives no abort.
- Balance saturation.
  - Drive balance[1] to 3 and bid 9. Required: charge of 3 and balance 0. Then bid 0 against another master's bid 0: the tie is resolved by age.
  - Idle 64 cycles from INIT_BAL 900 (MAX_BAL 1000). Required: balance 950, then 1000, and it stays at 1000.
- Assert rst while in GRANT.
  - Required: grant drops immediately with no clock.
  - Required: balances return to 900 and the FSM is in IDLE on release.
